// File: rtl/useq_sequencer_p.sv
// 2910-class microprogram sequencer: selects the next microaddress from D, R, uPC, stack top or zero,
// with a loop counter, a LIFO subroutine stack, a HOLD stall and sticky stack error flags.
module useq_sequencer_p #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned STACK_DEPTH = 5,
   localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              RST_BAR,
   input  logic [3:0]        I,
   input  logic              CCEN_BAR,
   input  logic              CC_BAR,
   input  logic              RLD_BAR,
   input  logic              CI,
   input  logic              HOLD,
   input  logic              ERR_CLR,
   input  logic [ADDR_W-1:0] D,
   output logic [ADDR_W-1:0] Y,
   output logic              PL_BAR,
   output logic              MAP_BAR,
   output logic              VECT_BAR,
   output logic              FULL_BAR,
   output logic              EMPTY,
   output logic [SP_W-1:0]   SP,
   output logic              STK_OVF,
   output logic              STK_UDF
);

   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

   typedef enum logic [3:0] {
      OP_JZ, OP_CJS, OP_JMAP, OP_CJP, OP_PUSH, OP_JSRP, OP_CJV, OP_JRP,
      OP_RFCT, OP_RPCT, OP_CRTN, OP_CJPP, OP_LDCT, OP_LOOP, OP_CONT, OP_TWB
   } op_e;

   typedef enum logic [2:0] {SRC_D, SRC_R, SRC_UPC, SRC_TOS, SRC_ZERO} src_e;

   logic [ADDR_W-1:0] upc;
   logic [CNT_W-1:0]  r;
   logic [SP_W-1:0]   sp;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];
   logic              ovf, udf;

   op_e               op;
   src_e              src;
   logic              fail, rz, empty, full;
   logic [ADDR_W-1:0] tos, r_ext;
   logic              push, pop, load_r, dec_r, clr_sp;

   assign op    = op_e'(I);
   assign fail  = ~CCEN_BAR & CC_BAR;
   assign rz    = (r == '0);
   assign empty = (sp == '0);
   assign full  = (sp == SP_W'(STACK_DEPTH));
   // An empty stack reads as zero rather than a stale entry.
   assign tos   = empty ? '0 : stack[IDX_W'(sp - SP_W'(1))];

   always_comb begin
      r_ext = '0;
      r_ext[CNT_W-1:0] = r;
   end

   always_comb begin
      src    = SRC_UPC;
      push   = 1'b0;
      pop    = 1'b0;
      load_r = 1'b0;
      dec_r  = 1'b0;
      clr_sp = 1'b0;
      case (op)
         OP_JZ:   begin src = SRC_ZERO; clr_sp = 1'b1; end
         OP_CJS:  if (!fail) begin src = SRC_D; push = 1'b1; end
         OP_JMAP: src = SRC_D;
         OP_CJP:  if (!fail) src = SRC_D;
         OP_PUSH: begin push = 1'b1; load_r = !fail; end
         OP_JSRP: begin push = 1'b1; src = fail ? SRC_R : SRC_D; end
         OP_CJV:  if (!fail) src = SRC_D;
         OP_JRP:  src = fail ? SRC_R : SRC_D;
         OP_RFCT: if (!rz) begin src = SRC_TOS; dec_r = 1'b1; end else pop = 1'b1;
         OP_RPCT: if (!rz) begin src = SRC_D; dec_r = 1'b1; end
         OP_CRTN: if (!fail) begin src = SRC_TOS; pop = 1'b1; end
         OP_CJPP: if (!fail) begin src = SRC_D; pop = 1'b1; end
         OP_LDCT: load_r = 1'b1;
         OP_LOOP: if (!fail) pop = 1'b1; else src = SRC_TOS;
         OP_CONT: ;
         OP_TWB: begin
            dec_r = !rz;
            if (!fail)   pop = 1'b1;
            else if (!rz) src = SRC_TOS;
            else begin src = SRC_D; pop = 1'b1; end
         end
         default: ;
      endcase
   end

   always_comb begin
      case (src)
         SRC_D:    Y = D;
         SRC_R:    Y = r_ext;
         SRC_TOS:  Y = tos;
         SRC_ZERO: Y = '0;
         default:  Y = upc;
      endcase
   end

   assign MAP_BAR  = (op != OP_JMAP);
   assign VECT_BAR = (op != OP_CJV);
   assign PL_BAR   = (op == OP_JMAP) || (op == OP_CJV);
   assign FULL_BAR = ~full;
   assign EMPTY    = empty;
   assign SP       = sp;
   assign STK_OVF  = ovf;
   assign STK_UDF  = udf;

   always_ff @(posedge clk or negedge RST_BAR) begin
      if (!RST_BAR) begin
         upc <= '0;
         r   <= '0;
         sp  <= '0;
         ovf <= 1'b0;
         udf <= 1'b0;
         for (int unsigned k = 0; k < STACK_DEPTH; k++) stack[IDX_W'(k)] <= '0;
      end else if (!HOLD) begin
         upc <= Y + ADDR_W'(CI);
         if (!RLD_BAR || load_r) r <= D[CNT_W-1:0];
         else if (dec_r)         r <= r - CNT_W'(1);
         // Clear first so that a flag set in the same cycle takes precedence.
         if (ERR_CLR) begin
            ovf <= 1'b0;
            udf <= 1'b0;
         end
         if (clr_sp) sp <= '0;
         else if (push) begin
            if (full) begin
               stack[IDX_W'(STACK_DEPTH - 1)] <= upc;
               ovf <= 1'b1;
            end else begin
               stack[IDX_W'(sp)] <= upc;
               sp <= sp + SP_W'(1);
            end
         end else if (pop) begin
            if (empty) udf <= 1'b1;
            else       sp  <= sp - SP_W'(1);
         end
         if (src == SRC_TOS && empty) udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_useq_sequencer_p.sv
// Directed bench for useq_sequencer_p: hand-computed Y, SP, counter and flag values per step.
module tb_useq_sequencer_p;

   logic        clk = 1'b0;
   logic        RST_BAR, CCEN_BAR, CC_BAR, RLD_BAR, CI, HOLD, ERR_CLR;
   logic [3:0]  I;
   logic [11:0] D, Y;
   logic        PL_BAR, MAP_BAR, VECT_BAR, FULL_BAR, EMPTY, STK_OVF, STK_UDF;
   logic [2:0]  SP;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   useq_sequencer_p #(.ADDR_W(12), .CNT_W(12), .STACK_DEPTH(5)) dut (
      .clk(clk), .RST_BAR(RST_BAR), .I(I), .CCEN_BAR(CCEN_BAR), .CC_BAR(CC_BAR),
      .RLD_BAR(RLD_BAR), .CI(CI), .HOLD(HOLD), .ERR_CLR(ERR_CLR), .D(D), .Y(Y),
      .PL_BAR(PL_BAR), .MAP_BAR(MAP_BAR), .VECT_BAR(VECT_BAR), .FULL_BAR(FULL_BAR),
      .EMPTY(EMPTY), .SP(SP), .STK_OVF(STK_OVF), .STK_UDF(STK_UDF)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // pass: condition enabled and true; fail: condition enabled and false
   task automatic set(input logic [3:0] i, input logic pass, input logic [11:0] d, input logic ci);
      I        = i;
      CCEN_BAR = 1'b0;
      CC_BAR   = ~pass;
      D        = d;
      CI       = ci;
      #1;
   endtask

   task automatic peek_upc(input string tag, input logic [31:0] exp);
      I = 4'd14;
      #1;
      check(tag, 32'(Y), exp);
   endtask

   task automatic peek_r(input string tag, input logic [31:0] exp);
      I = 4'd7; CCEN_BAR = 1'b0; CC_BAR = 1'b1;
      #1;
      check(tag, 32'(Y), exp);
   endtask

   initial begin
      RST_BAR = 1'b0; HOLD = 1'b0; ERR_CLR = 1'b0; RLD_BAR = 1'b1;
      set(4'd14, 1'b1, 12'h000, 1'b1);
      #10 RST_BAR = 1'b1;

      // T1: run a little, push, then reset asynchronously mid-cycle
      tick; tick; tick;
      set(4'd4, 1'b0, 12'h000, 1'b1);
      tick;
      check("pre_rst_sp", 32'(SP), 1);
      #2 RST_BAR = 1'b0;
      #1;
      check("rst_sp", 32'(SP), 0);
      check("rst_empty", 32'(EMPTY), 1);
      check("rst_full_bar", 32'(FULL_BAR), 1);
      check("rst_ovf", 32'(STK_OVF), 0);
      check("rst_udf", 32'(STK_UDF), 0);
      set(4'd14, 1'b1, 12'h000, 1'b1);
      check("rst_upc", 32'(Y), 0);
      check("cont_pl", 32'(PL_BAR), 0);
      #2 RST_BAR = 1'b1;
      for (int n = 0; n < 3; n++) begin
         check("cont_seq", 32'(Y), 32'(n));
         tick;
      end

      // Strobes and CJV/JMAP sources (combinational only), uPC = 3
      set(4'd2, 1'b1, 12'h0AB, 1'b1);
      check("jmap_y", 32'(Y), 'h0AB);
      check("jmap_map", 32'(MAP_BAR), 0);
      check("jmap_pl", 32'(PL_BAR), 1);
      check("jmap_vect", 32'(VECT_BAR), 1);
      set(4'd6, 1'b1, 12'h0CD, 1'b1);
      check("cjv_pass_y", 32'(Y), 'h0CD);
      check("cjv_vect", 32'(VECT_BAR), 0);
      check("cjv_pl", 32'(PL_BAR), 1);
      set(4'd6, 1'b0, 12'h0CD, 1'b1);
      check("cjv_fail_y", 32'(Y), 3);

      // T2: subroutine call and return
      set(4'd3, 1'b1, 12'h00F, 1'b1);
      tick;
      peek_upc("t2_upc", 'h010);
      set(4'd1, 1'b1, 12'h200, 1'b1);
      check("cjs_y", 32'(Y), 'h200);
      tick;
      check("cjs_sp", 32'(SP), 1);
      check("cjs_empty", 32'(EMPTY), 0);
      set(4'd13, 1'b0, 12'h000, 1'b1);
      check("cjs_tos", 32'(Y), 'h010);
      set(4'd10, 1'b1, 12'h000, 1'b1);
      check("crtn_y", 32'(Y), 'h010);
      tick;
      check("crtn_sp", 32'(SP), 0);
      check("crtn_empty", 32'(EMPTY), 1);
      check("crtn_udf", 32'(STK_UDF), 0);

      // T3: counted loop with RFCT
      set(4'd3, 1'b1, 12'h03E, 1'b1);
      tick;
      set(4'd12, 1'b1, 12'h003, 1'b1);
      check("ldct_y", 32'(Y), 'h03F);
      tick;
      peek_r("ldct_r", 3);
      set(4'd4, 1'b0, 12'h000, 1'b1);
      check("t3_push_y", 32'(Y), 'h040);
      tick;
      check("t3_push_sp", 32'(SP), 1);
      for (int k = 0; k < 3; k++) begin
         set(4'd8, 1'b1, 12'h000, 1'b1);
         check("rfct_loop_y", 32'(Y), 'h040);
         tick;
      end
      set(4'd8, 1'b1, 12'h000, 1'b1);
      check("rfct_exit_y", 32'(Y), 'h041);
      tick;
      check("rfct_exit_sp", 32'(SP), 0);
      check("rfct_exit_udf", 32'(STK_UDF), 0);
      peek_r("rfct_r", 0);

      // T4: overflow, set-wins over ERR_CLR, clear, then JZ
      for (int n = 0; n < 5; n++) begin
         set(4'd4, 1'b0, 12'h000, 1'b1);
         tick;
         if (n == 3) check("ovf_full_bar_4", 32'(FULL_BAR), 1);
      end
      check("ovf_sp5", 32'(SP), 5);
      check("ovf_full_bar_5", 32'(FULL_BAR), 0);
      check("ovf_flag_pre", 32'(STK_OVF), 0);
      set(4'd4, 1'b0, 12'h000, 1'b1);
      tick;
      check("ovf_sp_hold", 32'(SP), 5);
      check("ovf_flag", 32'(STK_OVF), 1);
      set(4'd13, 1'b0, 12'h000, 1'b1);
      check("ovf_top", 32'(Y), 'h047);
      ERR_CLR = 1'b1;
      set(4'd4, 1'b0, 12'h000, 1'b1);
      tick;
      check("ovf_set_wins", 32'(STK_OVF), 1);
      set(4'd14, 1'b1, 12'h000, 1'b1);
      tick;
      ERR_CLR = 1'b0;
      check("ovf_clr", 32'(STK_OVF), 0);
      set(4'd10, 1'b1, 12'h000, 1'b1);
      check("ovf_pop_y", 32'(Y), 'h048);
      tick;
      check("ovf_pop_sp", 32'(SP), 4);
      set(4'd13, 1'b0, 12'h000, 1'b1);
      check("ovf_below_top", 32'(Y), 'h045);
      set(4'd0, 1'b1, 12'h000, 1'b1);
      check("jz_y", 32'(Y), 0);
      tick;
      check("jz_sp", 32'(SP), 0);
      check("jz_empty", 32'(EMPTY), 1);
      check("jz_udf", 32'(STK_UDF), 0);
      check("jz_ovf", 32'(STK_OVF), 0);

      // T5: underflow on empty return, then HOLD freezes everything
      set(4'd10, 1'b1, 12'h000, 1'b1);
      check("udf_y", 32'(Y), 0);
      tick;
      check("udf_flag", 32'(STK_UDF), 1);
      check("udf_sp", 32'(SP), 0);
      HOLD = 1'b1; ERR_CLR = 1'b1; RLD_BAR = 1'b0;
      set(4'd4, 1'b1, 12'h05A, 1'b1);
      check("hold_y", 32'(Y), 1);
      tick;
      HOLD = 1'b0; ERR_CLR = 1'b0; RLD_BAR = 1'b1;
      check("hold_sp", 32'(SP), 0);
      check("hold_udf", 32'(STK_UDF), 1);
      peek_upc("hold_upc", 1);
      peek_r("hold_r", 0);
      ERR_CLR = 1'b1;
      set(4'd14, 1'b1, 12'h000, 1'b1);
      tick;
      ERR_CLR = 1'b0;
      check("udf_clr", 32'(STK_UDF), 0);

      // RLD_BAR load at RZ, then RPCT branch with decrement
      RLD_BAR = 1'b0;
      set(4'd9, 1'b1, 12'h007, 1'b1);
      check("rpct_rz_y", 32'(Y), 2);
      tick;
      RLD_BAR = 1'b1;
      peek_r("rld_r", 7);
      set(4'd9, 1'b1, 12'h300, 1'b0);
      check("rpct_y", 32'(Y), 'h300);
      tick;
      peek_r("rpct_r", 6);

      // T6: TWB, then uPC wrap
      set(4'd12, 1'b1, 12'h002, 1'b1);
      tick;
      set(4'd4, 1'b0, 12'h000, 1'b1);
      tick;
      for (int k = 0; k < 2; k++) begin
         set(4'd15, 1'b0, 12'h123, 1'b1);
         check("twb_tos_y", 32'(Y), 'h301);
         tick;
      end
      set(4'd15, 1'b0, 12'h123, 1'b1);
      check("twb_d_y", 32'(Y), 'h123);
      tick;
      check("twb_sp", 32'(SP), 0);
      peek_r("twb_r", 0);
      set(4'd3, 1'b1, 12'hFFF, 1'b0);
      tick;
      set(4'd14, 1'b1, 12'h000, 1'b1);
      check("wrap_y", 32'(Y), 'hFFF);
      tick;
      peek_upc("wrap_upc", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
